// File: rtl/seg_pkg.sv
// Shared 7-segment patterns ({dp,g,f,e,d,c,b,a}, active-high) and the
// converter state encoding for the seg_scan_bcd block.
package seg_pkg;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with overflow flag.
// Latency: DATA_W+1 cycles from start to the done pulse; bcd/ovf valid while done=1.
// Backpressure: start is ignored while busy; no queueing.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  conv_state_t        state, state_nxt;
  logic [DATA_W-1:0]  bin_sh;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      adj;

  // Add-3 correction on every nibble before the shift
  always_comb begin
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bin_sh <= '0;
      cnt    <= '0;
      bcd    <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          bin_sh <= bin;
          cnt    <= '0;
          bcd    <= '0;
          ovf    <= 1'b0;
        end
        SHIFT: begin
          // A 1 leaving the top nibble means the value needs more digits
          bcd    <= {adj[BW-2:0], bin_sh[DATA_W-1]};
          bin_sh <= bin_sh << 1;
          cnt    <= cnt + CW'(1);
          if (adj[BW-1]) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/seg_scan_bcd.sv
// Binary-to-BCD display driver scanning DIGITS seven-segment digits.
// Latency: load at t -> display at t+DATA_W+2; SEG/AN registered, 1 cycle behind the digit index.
// Backpressure: load ignored while busy.
module seg_scan_bcd
  import seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DATA_W         = 8,
  parameter int SCAN_DIV       = 100_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  input  logic              blank_lz,
  output logic              busy,
  output logic [7:0]        SEG,
  output logic [DIGITS-1:0] AN
);

  localparam int BW = 4 * DIGITS;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic          INV     = (SEG_ACTIVE_LOW != 0);

  logic          conv_done, conv_ovf;
  logic [BW-1:0] conv_bcd;
  logic [BW-1:0] disp_bcd;
  logic          disp_ovf;
  logic [DW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic          tick;
  logic [3:0]    nib;
  logic          upper_zero;
  logic [7:0]    pat;
  logic [DIGITS-1:0] an_hot;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (value),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd;
      disp_ovf <= conv_ovf;
    end
  end

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Select the current nibble and check whether it and all above are zero
  always_comb begin
    nib        = 4'd0;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx) nib = disp_bcd[4*k +: 4];
      if (IW'(k) >= idx && disp_bcd[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
  end

  always_comb begin
    pat = SEG_OFF;
    if (disp_ovf) begin
      pat = SEG_DASH;
    end else if (!(blank_lz && idx != '0 && upper_zero)) begin
      case (nib)
        4'd0:    pat = SEG_0;
        4'd1:    pat = SEG_1;
        4'd2:    pat = SEG_2;
        4'd3:    pat = SEG_3;
        4'd4:    pat = SEG_4;
        4'd5:    pat = SEG_5;
        4'd6:    pat = SEG_6;
        4'd7:    pat = SEG_7;
        4'd8:    pat = SEG_8;
        4'd9:    pat = SEG_9;
        default: pat = SEG_OFF;
      endcase
    end
  end

  assign an_hot = DIGITS'(1) << idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      SEG <= INV ? 8'hFF : 8'h00;
      AN  <= INV ? '1 : '0;
    end else begin
      SEG <= INV ? ~pat : pat;
      AN  <= INV ? ~an_hot : an_hot;
    end
  end

endmodule
